// File: rtl/memory_1.sv
// Block-organised main memory: 64 blocks x 4 words, whole-block transfers.
// Optional MEM_INIT_PATTERN_EN: reset loads word k with value k instead of 0.
module memory_1 (
    input  logic         clk,
    input  logic         reset,
    input  logic         read_write,
    input  logic [9:0]   address,
    input  logic [127:0] writeData,
    output logic [127:0] readData
);

    logic [31:0] r_mem [0:255];
    logic [5:0]  w_blk;

    assign w_blk = address[9:4];

    function automatic logic [31:0] init_word(input int k);
`ifdef MEM_INIT_PATTERN_EN
        init_word = 32'(k);
`else
        init_word = 32'h0;
`endif
    endfunction

    // Reset dominates, so a write pending when reset rises is discarded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 256; k++) begin
                r_mem[k] <= init_word(k);
            end
        end else if (read_write) begin
            for (int w = 0; w < 4; w++) begin
                r_mem[{w_blk, 2'(w)}] <= writeData[32*w +: 32];
            end
        end
    end

    always_comb begin
        readData = '0;
        for (int w = 0; w < 4; w++) begin
            readData[32*w +: 32] = r_mem[{w_blk, 2'(w)}];
        end
    end

endmodule

// File: tb/tb_memory_1.sv
// Self-checking bench for memory_1: directed steps plus randomized traffic
// compared against an array-based reference model.
module tb_memory_1;

    logic         clk;
    logic         reset;
    logic         read_write;
    logic [9:0]   address;
    logic [127:0] writeData;
    logic [127:0] readData;

    int checks;
    int errors;

    logic [31:0] mdl [256];

    memory_1 dut (
        .clk        (clk),
        .reset      (reset),
        .read_write (read_write),
        .address    (address),
        .writeData  (writeData),
        .readData   (readData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rst_val(input int k);
`ifdef MEM_INIT_PATTERN_EN
        return 32'(k);
`else
        return 32'h0;
`endif
    endfunction

    task automatic mdl_reset();
        for (int k = 0; k < 256; k++) mdl[k] = rst_val(k);
    endtask

    function automatic logic [127:0] mdl_block(input logic [9:0] a);
        int b;
        b = int'(a) / 16;
        return {mdl[4*b+3], mdl[4*b+2], mdl[4*b+1], mdl[4*b]};
    endfunction

    task automatic mdl_write(input logic [9:0] a, input logic [127:0] d);
        int b;
        b = int'(a) / 16;
        for (int w = 0; w < 4; w++) mdl[4*b+w] = d[32*w +: 32];
    endtask

    task automatic chk(input string tag, input logic [127:0] exp);
        checks++;
        assert (readData === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, readData, exp);
        end
    endtask

    // Drive one access at the falling edge, let it commit, then sample.
    task automatic op(input logic rw, input logic [9:0] a,
                      input logic [127:0] d);
        @(negedge clk);
        read_write = rw;
        address    = a;
        writeData  = d;
        @(posedge clk);
        if (rw && !reset) mdl_write(a, d);
        #1;
    endtask

    logic [127:0] v;
    logic [127:0] old;
    logic [9:0]   ra;

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        read_write = 1'b0;
        address    = 10'h000;
        writeData  = '0;
        mdl_reset();

        #2;
        chk("rst_rd_000", mdl_block(10'h000));
        address = 10'h3F0;
        #1;
        chk("rst_rd_3F0", mdl_block(10'h3F0));
        address = 10'h010;
        #1;
        chk("rst_rd_010", mdl_block(10'h010));
`ifdef MEM_INIT_PATTERN_EN
        chk("rst_pat_010", 128'h00000007_00000006_00000005_00000004);
`else
        chk("rst_zero_010", 128'h0);
`endif

        @(negedge clk);
        reset = 1'b0;

        v = 128'h11111111_22222222_33333333_44444444;
        old = mdl_block(10'h0B0);
        @(negedge clk);
        read_write = 1'b1;
        address    = 10'h0A0;
        writeData  = v;
        #1;
        chk("pre_edge_old", mdl_block(10'h0A0));
        @(posedge clk);
        mdl_write(10'h0A0, v);
        #1;
        chk("wr_rd_0A0", v);
        op(1'b0, 10'h0AC, '0);
        chk("rd_0AC", v);
        op(1'b0, 10'h0B0, '0);
        chk("rd_0B0_unch", old);

        op(1'b1, 10'h12F, 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF);
        address = 10'h120;
        #1;
        checks++;
        assert (readData[31:0] === 32'hDEADBEEF) else begin
            errors++;
            $error("FAIL nibble_ign observed %h expected deadbeef",
                   readData[31:0]);
        end

        op(1'b1, 10'h040, 128'h5A5A5A5A_0F0F0F0F_12345678_9ABCDEF0);
        for (int i = 0; i < 3; i++) op(1'b0, 10'h040, '1);
        chk("rw0_nowrite", 128'h5A5A5A5A_0F0F0F0F_12345678_9ABCDEF0);

        op(1'b1, 10'h0A4, 128'h1);
        op(1'b1, 10'h0A8, 128'h2);
        chk("last_wins", 128'h2);

        @(negedge clk);
        read_write = 1'b1;
        address    = 10'h200;
        writeData  = {4{32'hAAAAAAAA}};
        #2;
        reset = 1'b1;
        mdl_reset();
        #1;
        chk("rst_async_clr", mdl_block(10'h200));
        @(posedge clk);
        #1;
        chk("rst_mid_wr", mdl_block(10'h200));
        address = 10'h0A0;
        #1;
        chk("rst_clr_0A0", mdl_block(10'h0A0));
        @(negedge clk);
        reset      = 1'b0;
        read_write = 1'b0;
        op(1'b1, 10'h200, {4{32'hAAAAAAAA}});
        chk("post_rst_wr", {4{32'hAAAAAAAA}});

        for (int i = 0; i < 300; i++) begin
            ra = 10'($urandom);
            v  = {$urandom, $urandom, $urandom, $urandom};
            op(1'($urandom_range(0, 1)), ra, v);
            ra = 10'($urandom);
            address = ra;
            #1;
            chk("rand_rd", mdl_block(ra));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
